raster_tri_scheduler: RTL and testbench
=======================================

Name: raster_tri_scheduler

Overview:
- Front-end controller for the per-pixel edge-function raster cores.
- Accepts triangle vertices over a valid/ready stream and sorts each triangle's three vertices into the order the raster core requires: V0 largest X, V1 middle, V2 smallest.
- Holds NUM_TRI triangle slots, double-buffered so that new triangles become visible only at a frame boundary.
- Merges the per-slot rasterize bits from external raster core instances into one prioritised pixel colour.

Parameters:
- NUM_TRI, 2, number of triangle slots and raster core instances served (1..4).
- BG_COLOR, 6'b000000, RGB222 colour output when no valid slot hits.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- vtx_valid  in  1  vertex beat valid
- vtx_ready  out  1  block can accept a vertex beat
- vtx_x  in  10  vertex column
- vtx_y  in  9  vertex row
- vtx_slot  in  2  target slot; sampled on beat 0 only
- vtx_color  in  6  triangle RGB222 colour; sampled on beat 0 only
- frame_start  in  1  one-cycle pulse at frame start (end of vblank)
- tri_x  out  30*NUM_TRI  active vertex X per slot; slot k at [30k+29:30k] = {v2_x, v1_x, v0_x}
- tri_y  out  27*NUM_TRI  active vertex Y per slot; slot k at [27k+26:27k] = {v2_y, v1_y, v0_y}
- raster_in  in  NUM_TRI  rasterize bit from each slot's raster core for the current pixel
- pix_color  out  6  registered pixel colour
- pix_hit  out  1  registered: some valid slot covered the pixel
- busy  out  1  high from the beat-2 handshake through the COMMIT cycle

Behaviour:
- Reset: FSM returns to LOAD0. vtx_ready=1, busy=0. All shadow and active slots are cleared: coordinates=0, colour=0, valid=0. tri_x=0, tri_y=0, pix_color=BG_COLOR, pix_hit=0.
- Handshake: a beat transfers when vtx_valid && vtx_ready on a rising edge. vtx_ready=1 only in LOAD0/LOAD1/LOAD2 and is a combinational decode of the FSM state.
- FSM:
  - LOAD0: on a transfer, capture x, y, slot, colour into working register w0, then go to LOAD1.
  - LOAD1: on a transfer, capture w1, then go to LOAD2.
  - LOAD2: on a transfer, capture w2, then go to SORT.
  - SORT: 3 cycles, one compare-swap per cycle: (w0,w1), then (w1,w2), then (w0,w1). A swap occurs only if the lower-indexed X is strictly less than the higher-indexed X. The result is descending X; equal X values keep arrival order (stable).
  - COMMIT: 1 cycle. Writes w0..w2 and colour into shadow[slot], sets shadow valid[slot]=1, then returns to LOAD0.
- Throughput: min 7 cycles per triangle (3 load + 3 sort + 1 commit). vtx_ready=0 for 4 cycles after the beat-2 handshake.
- A slot index >= NUM_TRI is accepted but the commit is dropped: no state change except the FSM advance.
- Y values travel with their X during swaps; Y never affects the ordering.
- Frame swap: on frame_start, the active bank (all coordinates, colours and valids) is loaded from the shadow bank in the same cycle.
  - If frame_start coincides with COMMIT, the active bank takes the pre-commit shadow; the new triangle appears at the next frame_start.
  - A partially loaded triangle is never visible.
- tri_x/tri_y are driven directly from the active bank registers.
- Pixel merge, 1-cycle latency:
  - On every clock, pix_hit <= OR over k of (raster_in[k] && active_valid[k]).
  - pix_color <= colour of the lowest-index slot satisfying that condition, else BG_COLOR.
  - Slot 0 has highest priority.
- The merge runs in every FSM state and is independent of loading.
- rst mid-load discards the working registers and clears both banks. A beat presented in the reset cycle is not accepted.

Test Plan:
- Reset, then probe: pix_color=BG_COLOR, pix_hit=0, vtx_ready=1, tri_x=0, and every raster_in pattern yields pix_hit=0 (all slots invalid).
- Load slot 0, colour 6'h30, beats x=100/300/200 with y=10/20/30; wait 4 cycles; pulse frame_start -> tri_x[29:0]={100,200,300}, tri_y[26:0]={10,30,20}. vtx_ready low exactly 4 cycles after the third beat.
- Tie ordering: beats x=50/50/10 with y=1/2/3 -> v0=(50,1), v1=(50,2), v2=(10,3).
- Without frame_start after commit -> active unchanged and pix_hit=0 for raster_in=2'b01. After the pulse, raster_in=2'b01 -> next cycle pix_color=6'h30, pix_hit=1.
- Slots 0 (colour 6'h30) and 1 (colour 6'h0C) both loaded and swapped in; raster_in=2'b11 -> 6'h30; 2'b10 -> 6'h0C; 2'b00 -> BG_COLOR, pix_hit=0.
- Assert rst after beat 1 of a load -> FSM in LOAD0 and both banks cleared. frame_start pulsed during COMMIT -> the new triangle is not visible until the following frame_start.

Source files
------------

// File: rtl/raster_tri_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : raster_tri_scheduler
// Brief    : Loads triangles over a vertex stream, sorts vertices by X and
//            double-buffers slots for raster cores; merges per-slot hits into
//            one prioritised pixel colour.
// Revision : 1.0 - initial release
// ============================================================================
module raster_tri_scheduler #(
    parameter int          NUM_TRI  = 2,
    parameter logic [5:0]  BG_COLOR = 6'b000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vtx_valid,
    output logic                    vtx_ready,
    input  logic [9:0]              vtx_x,
    input  logic [8:0]              vtx_y,
    input  logic [1:0]              vtx_slot,
    input  logic [5:0]              vtx_color,
    input  logic                    frame_start,
    output logic [30*NUM_TRI-1:0]   tri_x,
    output logic [27*NUM_TRI-1:0]   tri_y,
    input  logic [NUM_TRI-1:0]      raster_in,
    output logic [5:0]              pix_color,
    output logic                    pix_hit,
    output logic                    busy
);

    typedef enum logic [2:0] {
        S_LOAD0  = 3'd0,
        S_LOAD1  = 3'd1,
        S_LOAD2  = 3'd2,
        S_SORT0  = 3'd3,
        S_SORT1  = 3'd4,
        S_SORT2  = 3'd5,
        S_COMMIT = 3'd6
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_xfer;

    // Working vertex registers, arrival order until sorted in place
    logic [9:0] r_wx [3];
    logic [8:0] r_wy [3];
    logic [1:0] r_slot;
    logic [5:0] r_color;

    logic [29:0] r_sh_x  [NUM_TRI];
    logic [26:0] r_sh_y  [NUM_TRI];
    logic [5:0]  r_sh_c  [NUM_TRI];
    logic        r_sh_v  [NUM_TRI];
    logic [29:0] r_act_x [NUM_TRI];
    logic [26:0] r_act_y [NUM_TRI];
    logic [5:0]  r_act_c [NUM_TRI];
    logic        r_act_v [NUM_TRI];

    logic       w_hit;
    logic [5:0] w_color;

    assign w_xfer = vtx_valid && vtx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        vtx_ready = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_LOAD0: begin
                vtx_ready = 1'b1;
                if (vtx_valid) w_next = S_LOAD1;
            end
            S_LOAD1: begin
                vtx_ready = 1'b1;
                if (vtx_valid) w_next = S_LOAD2;
            end
            S_LOAD2: begin
                vtx_ready = 1'b1;
                if (vtx_valid) w_next = S_SORT0;
            end
            S_SORT0: begin
                busy   = 1'b1;
                w_next = S_SORT1;
            end
            S_SORT1: begin
                busy   = 1'b1;
                w_next = S_SORT2;
            end
            S_SORT2: begin
                busy   = 1'b1;
                w_next = S_COMMIT;
            end
            S_COMMIT: begin
                busy   = 1'b1;
                w_next = S_LOAD0;
            end
            default: w_next = S_LOAD0;
        endcase
    end

    // Three-pass bubble network; strict compare keeps equal X in arrival order
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                r_wx[i] <= '0;
                r_wy[i] <= '0;
            end
            r_slot  <= '0;
            r_color <= '0;
        end else begin
            case (r_state)
                S_LOAD0: begin
                    if (w_xfer) begin
                        r_wx[0] <= vtx_x;
                        r_wy[0] <= vtx_y;
                        r_slot  <= vtx_slot;
                        r_color <= vtx_color;
                    end
                end
                S_LOAD1: begin
                    if (w_xfer) begin
                        r_wx[1] <= vtx_x;
                        r_wy[1] <= vtx_y;
                    end
                end
                S_LOAD2: begin
                    if (w_xfer) begin
                        r_wx[2] <= vtx_x;
                        r_wy[2] <= vtx_y;
                    end
                end
                S_SORT0, S_SORT2: begin
                    if (r_wx[0] < r_wx[1]) begin
                        r_wx[0] <= r_wx[1];
                        r_wx[1] <= r_wx[0];
                        r_wy[0] <= r_wy[1];
                        r_wy[1] <= r_wy[0];
                    end
                end
                S_SORT1: begin
                    if (r_wx[1] < r_wx[2]) begin
                        r_wx[1] <= r_wx[2];
                        r_wx[2] <= r_wx[1];
                        r_wy[1] <= r_wy[2];
                        r_wy[2] <= r_wy[1];
                    end
                end
                default: ;
            endcase
        end
    end

    // Active bank copies the pre-commit shadow when frame_start meets COMMIT;
    // out-of-range slot indices match no k and are silently dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_TRI; k++) begin
                r_sh_x[k]  <= '0;
                r_sh_y[k]  <= '0;
                r_sh_c[k]  <= '0;
                r_sh_v[k]  <= 1'b0;
                r_act_x[k] <= '0;
                r_act_y[k] <= '0;
                r_act_c[k] <= '0;
                r_act_v[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NUM_TRI; k++) begin
                if (frame_start) begin
                    r_act_x[k] <= r_sh_x[k];
                    r_act_y[k] <= r_sh_y[k];
                    r_act_c[k] <= r_sh_c[k];
                    r_act_v[k] <= r_sh_v[k];
                end
                if ((r_state == S_COMMIT) && (r_slot == 2'(k))) begin
                    r_sh_x[k] <= {r_wx[2], r_wx[1], r_wx[0]};
                    r_sh_y[k] <= {r_wy[2], r_wy[1], r_wy[0]};
                    r_sh_c[k] <= r_color;
                    r_sh_v[k] <= 1'b1;
                end
            end
        end
    end

    // Walk from the highest index down so the lowest hitting slot wins
    always_comb begin
        w_hit   = 1'b0;
        w_color = BG_COLOR;
        for (int k = NUM_TRI - 1; k >= 0; k--) begin
            if (raster_in[k] && r_act_v[k]) begin
                w_hit   = 1'b1;
                w_color = r_act_c[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_color <= BG_COLOR;
            pix_hit   <= 1'b0;
        end else begin
            pix_color <= w_color;
            pix_hit   <= w_hit;
        end
    end

    generate
        for (genvar g = 0; g < NUM_TRI; g++) begin : g_slot_out
            assign tri_x[30*g +: 30] = r_act_x[g];
            assign tri_y[27*g +: 27] = r_act_y[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_raster_tri_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_raster_tri_scheduler
// Brief    : Scoreboard bench for raster_tri_scheduler (sorting, banking, merge).
// Revision : 1.0 - initial release
// ============================================================================
module tb_raster_tri_scheduler;

    localparam int         NUM_TRI  = 2;
    localparam logic [5:0] BG_COLOR = 6'b000000;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  vtx_valid = 1'b0;
    logic                  vtx_ready;
    logic [9:0]            vtx_x = '0;
    logic [8:0]            vtx_y = '0;
    logic [1:0]            vtx_slot = '0;
    logic [5:0]            vtx_color = '0;
    logic                  frame_start = 1'b0;
    logic [30*NUM_TRI-1:0] tri_x;
    logic [27*NUM_TRI-1:0] tri_y;
    logic [NUM_TRI-1:0]    raster_in = '0;
    logic [5:0]            pix_color;
    logic                  pix_hit;
    logic                  busy;

    int checks   = 0;
    int failures = 0;

    logic [6:0] sb [$];

    logic [29:0] m_sh_x  [NUM_TRI];
    logic [26:0] m_sh_y  [NUM_TRI];
    logic [5:0]  m_sh_c  [NUM_TRI];
    logic        m_sh_v  [NUM_TRI];
    logic [29:0] m_act_x [NUM_TRI];
    logic [26:0] m_act_y [NUM_TRI];
    logic [5:0]  m_act_c [NUM_TRI];
    logic        m_act_v [NUM_TRI];

    raster_tri_scheduler #(.NUM_TRI(NUM_TRI), .BG_COLOR(BG_COLOR)) dut (
        .clk         (clk),
        .rst         (rst),
        .vtx_valid   (vtx_valid),
        .vtx_ready   (vtx_ready),
        .vtx_x       (vtx_x),
        .vtx_y       (vtx_y),
        .vtx_slot    (vtx_slot),
        .vtx_color   (vtx_color),
        .frame_start (frame_start),
        .tri_x       (tri_x),
        .tri_y       (tri_y),
        .raster_in   (raster_in),
        .pix_color   (pix_color),
        .pix_hit     (pix_hit),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int k = 0; k < NUM_TRI; k++) begin
            m_sh_x[k] = '0; m_sh_y[k] = '0; m_sh_c[k] = '0; m_sh_v[k] = 1'b0;
            m_act_x[k] = '0; m_act_y[k] = '0; m_act_c[k] = '0; m_act_v[k] = 1'b0;
        end
    endtask

    task automatic model_swap();
        for (int k = 0; k < NUM_TRI; k++) begin
            m_act_x[k] = m_sh_x[k]; m_act_y[k] = m_sh_y[k];
            m_act_c[k] = m_sh_c[k]; m_act_v[k] = m_sh_v[k];
        end
    endtask

    function automatic logic [30*NUM_TRI-1:0] exp_tri_x();
        logic [30*NUM_TRI-1:0] v;
        for (int k = 0; k < NUM_TRI; k++) v[30*k +: 30] = m_act_x[k];
        return v;
    endfunction

    function automatic logic [27*NUM_TRI-1:0] exp_tri_y();
        logic [27*NUM_TRI-1:0] v;
        for (int k = 0; k < NUM_TRI; k++) v[27*k +: 27] = m_act_y[k];
        return v;
    endfunction

    // Drive one raster pattern, queue the model's expected merge result, clock once
    task automatic pix_push(input logic [NUM_TRI-1:0] r);
        logic       h;
        logic [5:0] c;
        h = 1'b0;
        c = BG_COLOR;
        for (int k = 0; k < NUM_TRI; k++) begin
            if (!h && r[k] && m_act_v[k]) begin
                h = 1'b1;
                c = m_act_c[k];
            end
        end
        raster_in = r;
        sb.push_back({h, c});
        tick();
        raster_in = '0;
    endtask

    task automatic frame_pulse(input string tag);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        model_swap();
        checks++;
        if (tri_x !== exp_tri_x() || tri_y !== exp_tri_y()) begin
            failures++;
            $display("FAIL %s tri_x=%h tri_y=%h expected tri_x=%h tri_y=%h",
                     tag, tri_x, tri_y, exp_tri_x(), exp_tri_y());
        end
    endtask

    // Three beats, then check the 4-cycle ready gap; optional frame_start on COMMIT
    task automatic load_tri(input logic [1:0] slot, input logic [5:0] col,
                            input logic [9:0] x0, input logic [9:0] x1, input logic [9:0] x2,
                            input logic [8:0] y0, input logic [8:0] y1, input logic [8:0] y2,
                            input bit fs_commit);
        logic [9:0] xs [3];
        logic [8:0] ys [3];
        int         ord [3];
        int         key, j, n, si;
        xs[0] = x0; xs[1] = x1; xs[2] = x2;
        ys[0] = y0; ys[1] = y1; ys[2] = y2;
        for (int b = 0; b < 3; b++) begin
            vtx_valid = 1'b1;
            vtx_x     = xs[b];
            vtx_y     = ys[b];
            vtx_slot  = (b == 0) ? slot : ~slot;
            vtx_color = (b == 0) ? col : ~col;
            n = 0;
            while (!vtx_ready && n < 20) begin
                tick();
                n++;
            end
            checks++;
            if (!vtx_ready) begin
                failures++;
                $display("FAIL load_ready_timeout beat=%0d vtx_ready=%b expected 1", b, vtx_ready);
            end
            tick();
        end
        vtx_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (vtx_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL sort_gap cycle=%0d vtx_ready=%b busy=%b expected 0/1", i, vtx_ready, busy);
            end
            if (i == 3 && fs_commit) frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
        end
        if (fs_commit) model_swap();
        checks++;
        if (vtx_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ready_return vtx_ready=%b busy=%b expected 1/0", vtx_ready, busy);
        end
        ord[0] = 0; ord[1] = 1; ord[2] = 2;
        for (int i = 1; i < 3; i++) begin
            key = ord[i];
            j = i - 1;
            while (j >= 0 && xs[ord[j]] < xs[key]) begin
                ord[j+1] = ord[j];
                j--;
            end
            ord[j+1] = key;
        end
        si = int'(slot);
        if (si < NUM_TRI) begin
            m_sh_x[si] = {xs[ord[2]], xs[ord[1]], xs[ord[0]]};
            m_sh_y[si] = {ys[ord[2]], ys[ord[1]], ys[ord[0]]};
            m_sh_c[si] = col;
            m_sh_v[si] = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [6:0] e;
        rst = 1'b1;
        vtx_valid = 1'b1;
        vtx_x = 10'd999;
        tick();
        tick();
        rst = 1'b0;
        vtx_valid = 1'b0;
        model_clear();
        checks++;
        if (pix_color !== BG_COLOR || pix_hit !== 1'b0 || vtx_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs pix=%h hit=%b ready=%b busy=%b expected %h/0/1/0",
                     pix_color, pix_hit, vtx_ready, busy, BG_COLOR);
        end
        checks++;
        if (tri_x !== '0 || tri_y !== '0) begin
            failures++;
            $display("FAIL reset_tri tri_x=%h tri_y=%h expected 0", tri_x, tri_y);
        end
        for (int p = 0; p < 4; p++) begin
            pix_push(2'(p));
            e = sb.pop_front();
            checks++;
            if ({pix_hit, pix_color} !== e || pix_hit !== 1'b0) begin
                failures++;
                $display("FAIL reset_merge pattern=%0d got=%h expected=%h", p, {pix_hit, pix_color}, e);
            end
        end
    endtask

    task automatic test_sort_basic();
        logic [6:0] e;
        load_tri(2'd0, 6'h30, 10'd100, 10'd300, 10'd200, 9'd10, 9'd20, 9'd30, 1'b0);
        tick(); tick(); tick(); tick();
        pix_push(2'b01);
        e = sb.pop_front();
        checks++;
        if ({pix_hit, pix_color} !== e || tri_x !== '0) begin
            failures++;
            $display("FAIL no_swap_yet got=%h tri_x=%h expected=%h tri_x=0", {pix_hit, pix_color}, tri_x, e);
        end
        frame_pulse("sort_basic_frame");
        checks++;
        if (tri_x[29:0] !== {10'd100, 10'd200, 10'd300} || tri_y[26:0] !== {9'd10, 9'd30, 9'd20}) begin
            failures++;
            $display("FAIL sort_basic_const tri_x=%h tri_y=%h expected %h %h", tri_x[29:0], tri_y[26:0],
                     {10'd100, 10'd200, 10'd300}, {9'd10, 9'd30, 9'd20});
        end
        pix_push(2'b01);
        e = sb.pop_front();
        checks++;
        if ({pix_hit, pix_color} !== e || {pix_hit, pix_color} !== 7'h70) begin
            failures++;
            $display("FAIL slot0_hit got=%h expected=%h", {pix_hit, pix_color}, e);
        end
    endtask

    task automatic test_priority();
        logic [6:0] e;
        logic [1:0] pats [4];
        pats[0] = 2'b11; pats[1] = 2'b10; pats[2] = 2'b00; pats[3] = 2'b01;
        load_tri(2'd1, 6'h0C, 10'd5, 10'd400, 10'd7, 9'd100, 9'd200, 9'd300, 1'b0);
        frame_pulse("priority_frame");
        for (int p = 0; p < 4; p++) begin
            pix_push(pats[p]);
            e = sb.pop_front();
            checks++;
            if ({pix_hit, pix_color} !== e) begin
                failures++;
                $display("FAIL priority pattern=%b got=%h expected=%h", pats[p], {pix_hit, pix_color}, e);
            end
        end
    endtask

    task automatic test_tie();
        load_tri(2'd0, 6'h30, 10'd50, 10'd50, 10'd10, 9'd1, 9'd2, 9'd3, 1'b0);
        frame_pulse("tie_frame");
        checks++;
        if (tri_x[29:0] !== {10'd10, 10'd50, 10'd50} || tri_y[26:0] !== {9'd3, 9'd2, 9'd1}) begin
            failures++;
            $display("FAIL tie_order tri_x=%h tri_y=%h expected %h %h", tri_x[29:0], tri_y[26:0],
                     {10'd10, 10'd50, 10'd50}, {9'd3, 9'd2, 9'd1});
        end
    endtask

    task automatic test_bad_slot();
        load_tri(2'd2, 6'h3F, 10'd1, 10'd2, 10'd3, 9'd4, 9'd5, 9'd6, 1'b0);
        load_tri(2'd3, 6'h3F, 10'd9, 10'd8, 10'd7, 9'd6, 9'd5, 9'd4, 1'b0);
        frame_pulse("bad_slot_frame");
    endtask

    task automatic test_commit_frame();
        logic [6:0] e;
        load_tri(2'd1, 6'h03, 10'd600, 10'd20, 10'd900, 9'd11, 9'd22, 9'd33, 1'b1);
        checks++;
        if (tri_x !== exp_tri_x() || tri_y !== exp_tri_y()) begin
            failures++;
            $display("FAIL commit_frame_hidden tri_x=%h expected=%h", tri_x, exp_tri_x());
        end
        pix_push(2'b10);
        e = sb.pop_front();
        checks++;
        if ({pix_hit, pix_color} !== e || pix_color !== 6'h0C) begin
            failures++;
            $display("FAIL commit_frame_old_color got=%h expected=%h", {pix_hit, pix_color}, e);
        end
        frame_pulse("commit_frame_next");
        pix_push(2'b10);
        e = sb.pop_front();
        checks++;
        if ({pix_hit, pix_color} !== e || pix_color !== 6'h03) begin
            failures++;
            $display("FAIL commit_frame_new_color got=%h expected=%h", {pix_hit, pix_color}, e);
        end
    endtask

    task automatic test_back_to_back();
        load_tri(2'd0, 6'h21, 10'd3, 10'd2, 10'd1, 9'd7, 9'd8, 9'd9, 1'b0);
        load_tri(2'd1, 6'h12, 10'd1, 10'd2, 10'd3, 9'd7, 9'd8, 9'd9, 1'b0);
        frame_pulse("back_to_back_frame");
    endtask

    task automatic test_mid_reset();
        logic [6:0] e;
        vtx_valid = 1'b1; vtx_x = 10'd77; vtx_y = 9'd1; vtx_slot = 2'd0; vtx_color = 6'h2A;
        tick();
        vtx_x = 10'd88;
        tick();
        rst = 1'b1;
        vtx_x = 10'd99;
        tick();
        rst = 1'b0;
        vtx_valid = 1'b0;
        model_clear();
        checks++;
        if (tri_x !== '0 || tri_y !== '0 || vtx_ready !== 1'b1 || busy !== 1'b0 || pix_hit !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset tri_x=%h tri_y=%h ready=%b busy=%b hit=%b expected 0/0/1/0/0",
                     tri_x, tri_y, vtx_ready, busy, pix_hit);
        end
        frame_pulse("mid_reset_shadow_cleared");
        pix_push(2'b11);
        e = sb.pop_front();
        checks++;
        if ({pix_hit, pix_color} !== e) begin
            failures++;
            $display("FAIL mid_reset_merge got=%h expected=%h", {pix_hit, pix_color}, e);
        end
        load_tri(2'd0, 6'h30, 10'd100, 10'd300, 10'd200, 9'd10, 9'd20, 9'd30, 1'b0);
        frame_pulse("mid_reset_reload");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        test_reset();
        test_sort_basic();
        test_priority();
        test_tie();
        test_bad_slot();
        test_commit_frame();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
